ula_arbitro_rr: RTL

//  Shares one 4-bit ULA datapath (AND/OR/NOT/NAND/ADD/SUB) between two requesters.

---
 rtl/ula_arbitro_rr.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/ula_arbitro_rr.sv
// ula_arbitro_rr: shares one small ALU (ULA) between two requesters.
// Requesters are granted round-robin. Each granted command has its operands
// latched, the result is registered, and the result is held until that
// requester takes it.
module ula_arbitro_rr #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [1:0]           req_valid,
    output logic [1:0]           req_ready,
    input  logic [5:0]           req_op,
    input  logic [2*WIDTH-1:0]   req_a,
    input  logic [2*WIDTH-1:0]   req_b,
    input  logic [1:0]           req_cin,
    output logic [1:0]           resp_valid,
    input  logic [1:0]           resp_ready,
    output logic [WIDTH-1:0]     resultado,
    output logic                 carry_out,
    output logic                 propagado,
    output logic                 gerado,
    output logic                 busy,
    output logic [CNT_W-1:0]     ops_done
);

    localparam int unsigned OP_W  = 3;
    localparam int unsigned SUM_W = WIDTH + 1;

    localparam logic [OP_W-1:0] OP_AND  = 3'b000;
    localparam logic [OP_W-1:0] OP_OR   = 3'b001;
    localparam logic [OP_W-1:0] OP_NOT  = 3'b010;
    localparam logic [OP_W-1:0] OP_NAND = 3'b011;
    localparam logic [OP_W-1:0] OP_ADD  = 3'b100;
    localparam logic [OP_W-1:0] OP_SUB  = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_RESP = 2'b10
    } state_t;

    state_t             state_q, state_d;
    logic               rr_ptr_q, rr_ptr_d;
    logic               grant_q, grant_d;
    logic [OP_W-1:0]    op_q, op_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic               cin_q, cin_d;
    logic [WIDTH-1:0]   res_q, res_d;
    logic               carry_q, carry_d;
    logic               prop_q, prop_d;
    logic               gen_q, gen_d;
    logic [CNT_W-1:0]   ops_q, ops_d;

    logic               grant_c;
    logic [OP_W-1:0]    sel_op_c;
    logic [WIDTH-1:0]   sel_a_c;
    logic [WIDTH-1:0]   sel_b_c;
    logic               sel_cin_c;

    logic [SUM_W-1:0]   sum_c;
    logic [SUM_W-1:0]   diff_c;
    logic [WIDTH-1:0]   alu_res_c;
    logic               alu_carry_c;
    logic               alu_prop_c;
    logic               alu_gen_c;

    // Pick the requester to serve: rr_ptr breaks a tie, a lone requester always wins.
    always_comb begin
        grant_c   = (req_valid == 2'b11) ? rr_ptr_q : req_valid[1];
        sel_op_c  = grant_c ? req_op[OP_W +: OP_W] : req_op[0 +: OP_W];
        sel_a_c   = grant_c ? req_a[WIDTH +: WIDTH] : req_a[0 +: WIDTH];
        sel_b_c   = grant_c ? req_b[WIDTH +: WIDTH] : req_b[0 +: WIDTH];
        sel_cin_c = req_cin[grant_c];
    end

    // ULA function on the latched operands; the borrow of SUB is the MSB of the widened difference.
    always_comb begin
        sum_c       = SUM_W'(a_q) + SUM_W'(b_q) + SUM_W'(cin_q);
        diff_c      = SUM_W'(a_q) - SUM_W'(b_q);
        alu_res_c   = '0;
        alu_carry_c = 1'b0;
        alu_prop_c  = 1'b0;
        alu_gen_c   = 1'b0;
        case (op_q)
            OP_AND:  alu_res_c = a_q & b_q;
            OP_OR:   alu_res_c = a_q | b_q;
            OP_NOT:  alu_res_c = ~a_q;
            OP_NAND: alu_res_c = ~(a_q & b_q);
            OP_ADD: begin
                alu_res_c   = sum_c[WIDTH-1:0];
                alu_carry_c = sum_c[WIDTH];
                alu_prop_c  = a_q[WIDTH-1] | b_q[WIDTH-1];
                alu_gen_c   = a_q[WIDTH-1] & b_q[WIDTH-1];
            end
            OP_SUB: begin
                alu_res_c   = diff_c[WIDTH-1:0];
                alu_carry_c = diff_c[WIDTH];
            end
            default: ;
        endcase
    end

    // Next-state and handshake outputs of the IDLE -> EXEC -> RESP sequence.
    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        grant_d    = grant_q;
        op_d       = op_q;
        a_d        = a_q;
        b_d        = b_q;
        cin_d      = cin_q;
        res_d      = res_q;
        carry_d    = carry_q;
        prop_d     = prop_q;
        gen_d      = gen_q;
        ops_d      = ops_q;
        req_ready  = 2'b00;
        resp_valid = 2'b00;
        busy       = (state_q != ST_IDLE);

        case (state_q)
            ST_IDLE: begin
                if (!rst && (req_valid != 2'b00)) begin
                    req_ready = grant_c ? 2'b10 : 2'b01;
                    grant_d   = grant_c;
                    op_d      = sel_op_c;
                    a_d       = sel_a_c;
                    b_d       = sel_b_c;
                    cin_d     = sel_cin_c;
                    state_d   = ST_EXEC;
                end
            end
            ST_EXEC: begin
                res_d   = alu_res_c;
                carry_d = alu_carry_c;
                prop_d  = alu_prop_c;
                gen_d   = alu_gen_c;
                state_d = ST_RESP;
            end
            ST_RESP: begin
                resp_valid = grant_q ? 2'b10 : 2'b01;
                if (resp_ready[grant_q]) begin
                    state_d  = ST_IDLE;
                    rr_ptr_d = ~grant_q;
                    if (ops_q != '1) begin
                        ops_d = ops_q + CNT_W'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers; reset drops any transaction in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            rr_ptr_q <= 1'b0;
            grant_q  <= 1'b0;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            cin_q    <= 1'b0;
            res_q    <= '0;
            carry_q  <= 1'b0;
            prop_q   <= 1'b0;
            gen_q    <= 1'b0;
            ops_q    <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            grant_q  <= grant_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            cin_q    <= cin_d;
            res_q    <= res_d;
            carry_q  <= carry_d;
            prop_q   <= prop_d;
            gen_q    <= gen_d;
            ops_q    <= ops_d;
        end
    end

    assign resultado = res_q;
    assign carry_out = carry_q;
    assign propagado = prop_q;
    assign gerado    = gen_q;
    assign ops_done  = ops_q;

endmodule
